// File: rtl/pattern_animator_if.sv
// rtl/pattern_animator_if.sv - control inputs and display outputs of the pattern animator
interface pattern_animator_if #(
   parameter int DIGITS = 3
);
   logic                  enable;
   logic [1:0]            mode;
   logic                  dir;
   logic [1:0]            speed;
   logic [8*DIGITS-1:0]   seg_n;
   logic                  step_tick;
   logic [4:0]            pos;

   modport master (
      output enable, mode, dir, speed,
      input  seg_n, step_tick, pos
   );

   modport slave (
      input  enable, mode, dir, speed,
      output seg_n, step_tick, pos
   );
endinterface

// File: rtl/pattern_animator.sv
// rtl/pattern_animator.sv - seven-segment idle animations (heartbeat, circle, sweep, blink)
module pattern_animator #(
   parameter int DIGITS   = 3,
   parameter int TICK_DIV = 4000000,
   parameter int TICK_W   = 22
) (
   input  logic              clk,
   input  logic              reset_n,
   pattern_animator_if.slave bus
);
   typedef enum logic [1:0] {HEARTBEAT = 2'd0, CIRCLE = 2'd1, SWEEP = 2'd2, BLINK = 2'd3} mode_t;

   localparam logic [TICK_W-1:0] DIV_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [4:0]        HB_MAX   = 5'((DIGITS - 1) / 2);
   localparam logic [4:0]        SW_MAX   = 5'(DIGITS - 1);
   localparam logic [4:0]        CI_MAX   = 5'(2 * DIGITS + 3);

   logic [TICK_W-1:0]   div_q;
   logic [2:0]          presc_q;
   logic [2:0]          mask;
   logic                base_tick;
   logic                step_hit;
   logic                step_q;
   mode_t               mode_q;
   mode_t               mode_in;
   logic                mode_change;
   logic [4:0]          pos_q, pos_d;
   logic                up_q, up_d;
   logic [4:0]          pp_max;
   logic [8*DIGITS-1:0] seg_q, seg_d;

   assign mode_in     = mode_t'(bus.mode);
   assign mode_change = (mode_in != mode_q);
   assign base_tick   = bus.enable && (div_q == DIV_LAST);

   always_comb begin
      mask = 3'b111;
      case (bus.speed)
         2'd0:    mask = 3'b000;
         2'd1:    mask = 3'b001;
         2'd2:    mask = 3'b011;
         default: mask = 3'b111;
      endcase
   end

   assign step_hit = ((presc_q & mask) == mask);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q   <= '0;
         presc_q <= '0;
         step_q  <= 1'b0;
         mode_q  <= HEARTBEAT;
         pos_q   <= '0;
         up_q    <= 1'b1;
         seg_q   <= '1;
      end else begin
         if (bus.enable)
            div_q <= base_tick ? '0 : div_q + 1'b1;
         if (base_tick)
            presc_q <= presc_q + 3'd1;
         step_q <= base_tick && step_hit;
         mode_q <= mode_in;
         pos_q  <= pos_d;
         up_q   <= up_d;
         seg_q  <= seg_d;
      end
   end

   // Mode change outranks a pending step; pos restarts at 0 going up.
   always_comb begin
      pos_d  = pos_q;
      up_d   = up_q;
      pp_max = (mode_q == SWEEP) ? SW_MAX : HB_MAX;
      if (mode_change) begin
         pos_d = '0;
         up_d  = 1'b1;
      end else if (step_q) begin
         case (mode_q)
            CIRCLE: begin
               if (bus.dir)
                  pos_d = (pos_q == 5'd0) ? CI_MAX : pos_q - 5'd1;
               else
                  pos_d = (pos_q >= CI_MAX) ? 5'd0 : pos_q + 5'd1;
            end
            BLINK: pos_d = {4'b0, ~pos_q[0]};
            default: begin
               if (pp_max == 5'd0) begin
                  pos_d = '0;
               end else if (up_q) begin
                  if (pos_q >= pp_max) begin
                     pos_d = pos_q - 5'd1;
                     up_d  = 1'b0;
                  end else begin
                     pos_d = pos_q + 5'd1;
                  end
               end else if (pos_q == 5'd0) begin
                  pos_d = 5'd1;
                  up_d  = 1'b1;
               end else begin
                  pos_d = pos_q - 5'd1;
               end
            end
         endcase
      end
   end

   always_comb begin
      int p;
      seg_d = '1;
      p     = int'(pos_q);
      for (int k = 0; k < DIGITS; k++) begin
         case (mode_q)
            HEARTBEAT: begin
               if (k == DIGITS - 1 - p) begin
                  seg_d[8*k+4] = 1'b0;
                  seg_d[8*k+5] = 1'b0;
               end
               if (k == p) begin
                  seg_d[8*k+1] = 1'b0;
                  seg_d[8*k+2] = 1'b0;
               end
            end
            CIRCLE: begin
               if (p < DIGITS && k == DIGITS - 1 - p)                 seg_d[8*k+0] = 1'b0;
               if (p == DIGITS && k == 0)                             seg_d[8*k+1] = 1'b0;
               if (p == DIGITS + 1 && k == 0)                         seg_d[8*k+2] = 1'b0;
               if (p >= DIGITS + 2 && p < 2*DIGITS + 2 && k == p - DIGITS - 2)
                                                                      seg_d[8*k+3] = 1'b0;
               if (p == 2*DIGITS + 2 && k == DIGITS - 1)              seg_d[8*k+4] = 1'b0;
               if (p == 2*DIGITS + 3 && k == DIGITS - 1)              seg_d[8*k+5] = 1'b0;
            end
            SWEEP: begin
               if (k == p) seg_d[8*k+6] = 1'b0;
            end
            default: begin
               if (!pos_q[0]) seg_d[8*k +: 7] = 7'b0;
            end
         endcase
      end
   end

   assign bus.seg_n     = seg_q;
   assign bus.step_tick = step_q;
   assign bus.pos       = pos_q;
endmodule

// File: doc/pattern_animator.md
PATTERN_ANIMATOR -- requirements
Module: pattern_animator

Interface
REQ-001 SHALL have parameter DIGITS, default 3: number of seven-segment digits driven, legal range 1..8.
REQ-002 SHALL have parameter TICK_DIV, default 4000000: clk cycles per base tick, at least 2.
REQ-003 SHALL have parameter TICK_W, default 22: divider counter width, with 2^TICK_W >= TICK_DIV.
REQ-004 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1: when high, the divider runs and the animation advances.
REQ-007 SHALL have port mode, input, 2: 0=HEARTBEAT, 1=CIRCLE, 2=SWEEP, 3=BLINK.
REQ-008 SHALL have port dir, input, 1: CIRCLE direction, 0=clockwise, 1=counter-clockwise.
REQ-009 SHALL have port speed, input, 2: advance once per 2^speed base ticks.
REQ-010 SHALL have port seg_n, output, 8*DIGITS: registered, active-low segments; digit k occupies bits [8k+7:8k], digit 0 is the rightmost; bit 0..6 = a..g, bit 7 = dp.
REQ-011 SHALL have port step_tick, output, 1: one-cycle pulse on every animation advance.
REQ-012 SHALL have port pos, output, 5: current animation position.

Function
REQ-013 SHALL count the divider 0..TICK_DIV-1 while enable=1, wrapping to 0, and hold its value while enable=0.
REQ-014 SHALL raise the base tick for the single cycle in which the divider equals TICK_DIV-1 and enable=1.
REQ-015 SHALL increment a prescaler on each base tick and assert step_tick on the base tick where prescaler[speed-1:0] are all ones (every tick when speed=0).
REQ-016 SHALL advance pos on the cycle following step_tick, plus a direction flag (up/down) for ping-pong modes.
REQ-017 SHALL in HEARTBEAT ping-pong q over 0..Q, Q=(DIGITS-1)/2 (integer division); e,f segments on digit DIGITS-1-q; b,c segments on digit q; both bars on one digit if equal; static at q=0 if Q=0.
REQ-018 SHALL in CIRCLE cycle r over 0..2*DIGITS+3, wrapping; dir=0 increments, dir=1 decrements; r<DIGITS lights a of digit DIGITS-1-r; r=DIGITS lights b of digit 0; r=DIGITS+1 lights c of digit 0; DIGITS+2<=r<2*DIGITS+2 lights d of digit r-DIGITS-2; r=2*DIGITS+2 lights e of digit DIGITS-1; r=2*DIGITS+3 lights f of digit DIGITS-1.
REQ-019 SHALL in SWEEP ping-pong over 0..DIGITS-1 and light segment g of digit pos; static when DIGITS=1.
REQ-020 SHALL in BLINK toggle pos[0]; pos[0]=0 lights segments a..g of all digits; pos[0]=1 blanks all digits.
REQ-021 SHALL make ping-pong reverse at the endpoints, so a sequence with Q=2 reads 0,1,2,1,0,1.
REQ-022 SHALL update seg_n one cycle after pos, so step_tick leads the displayed change by 2 cycles.
REQ-023 SHALL hold dp bits at 1 (off) at all times.
REQ-024 SHALL, on a mode change (mode differs from the registered previous mode), set pos=0 and direction=up on the next clock, without resetting divider or prescaler.
REQ-025 SHALL give mode change priority over a step_tick occurring in the same cycle.
REQ-026 SHALL apply a dir change only on the next step; pos itself does not jump.

Reset
REQ-027 SHALL, while reset_n=0, immediately force divider=0, prescaler=0, pos=0, direction=up, registered mode=0, step_tick=0, and seg_n all ones.
REQ-028 SHALL, after reset_n deasserts mid-animation, restart from pos 0, with the first step_tick TICK_DIV*2^speed enabled cycles later.

Verification
REQ-029 SHALL cover: DIGITS=3, TICK_DIV=4, speed=0, mode=0, enable=1 -> step_tick every 4 cycles; pos 0,1,0,1; seg_n alternates 0xCF_FF_F9 and 0xFF_C9_FF.
REQ-030 SHALL cover: mode=1, dir=0 -> pos 0..9 then 0; pos=3 gives seg_n 0xFF_FF_FD; dir=1 from pos 0 -> 9.
REQ-031 SHALL cover: speed=2 -> step_tick every 16 cycles; enable low for 10 cycles -> step interval stretches by 10 exactly.
REQ-032 SHALL cover: mode 2 to 3 when pos=2 -> next cycle pos=0; seg_n all digits 0x80 two cycles later.
REQ-033 SHALL cover: reset_n pulsed low asynchronously between edges -> seg_n=0xFFFFFF and pos=0 before the next clk edge.
REQ-034 SHALL cover: DIGITS=1, mode=0 and mode=2 -> pos stays 0; mode=1 cycles 0..5.
